seq_mult_hs: RTL and testbench
==============================

// Module: seq_mult_hs
// PURPOSE
//   Iterative shift-add multiplier with a valid/ready handshake on both sides.
//   Parametrised operand width and bits retired per cycle.
//   Supports per-transaction signed (two's complement) or unsigned operands.
//   Sits between an operand producer and a result consumer in the datapath.
//   Replaces the fixed 16-bit start-pulse multiplier where backpressure, signed
//   maths or a different width/latency is needed.
// PARAMETERS
//   WIDTH    16  operand width in bits; product is 2*WIDTH bits
//   RADIX_K  1   multiplier bits consumed per cycle; must divide WIDTH (1,2,4,...)
//   Derived: N_ITER = WIDTH/RADIX_K
// PORTS
//   clk          in   1        clock, rising edge
//   reset        in   1        asynchronous, active-high
//   in_valid     in   1        operands a/b/signed_mode valid
//   in_ready     out  1        block can accept operands (= state IDLE)
//   a            in   WIDTH    multiplicand
//   b            in   WIDTH    multiplier
//   signed_mode  in   1        1: a,b two's complement; 0: unsigned
//   out_valid    out  1        product valid, held until accepted
//   out_ready    in   1        consumer accepts product
//   product      out  2*WIDTH  registered result; holds last value
//   busy         out  1        state != IDLE
// BEHAVIOUR
//   Reset: state=IDLE, product=0, out_valid=0, internal regs=0.
//     in_ready=1 once state is IDLE. in_valid is ignored while reset is high.
//     Reset in any state aborts the operation. No partial result is emitted.
//   FSM: IDLE -> RUN -> FIX -> DONE -> IDLE.
//   IDLE: accept on in_valid&&in_ready. The accept edge latches the operands.
//     Latched values: |a|, |b| (magnitude if signed_mode and MSB=1), signed_mode,
//     neg = signed_mode & (a[MSB]^b[MSB]). Clear acc, iter=0, go to RUN.
//   RUN: each cycle add (mag_a * b_mag[RADIX_K-1:0]) << (iter*RADIX_K) into acc.
//     acc is 2*WIDTH unsigned. b_mag >>= RADIX_K, iter++.
//     After N_ITER cycles, go to FIX.
//   FIX (1 cycle): product <= neg ? -acc : acc. out_valid <= 1. Go to DONE.
//   DONE: hold product and out_valid while out_ready=0.
//     On out_valid&&out_ready: out_valid <= 0, go to IDLE.
//     product keeps its value after the handshake.
//   Latency: out_valid rises N_ITER+1 cycles after the accept edge.
//     Min issue interval is N_ITER+3 cycles. There is no overlap:
//     in_ready=0 in RUN/FIX/DONE, including the out handshake cycle.
//   Arithmetic: the result is exact, with no overflow in 2*WIDTH bits.
//     Signed -2^(W-1) * -2^(W-1) = +2^(2W-2). Its magnitude 2^(W-1) fits W-bit unsigned.
//   Zero operands still take the full N_ITER cycles (fixed latency).
//   Inputs a/b/signed_mode may change freely after the accept edge.
//   out_ready high while out_valid=0 has no effect.
// TESTING (WIDTH=16, RADIX_K=1 unless noted)
//   1. unsigned 3*5, out_ready=1 -> product=0x0000000F; out_valid exactly 17 cycles after accept.
//   2. unsigned 0xFFFF*0xFFFF -> 0xFFFE0001. Signed 0xFFFF*0xFFFF (-1*-1) -> 0x00000001.
//   3. signed 0x8000*0x8000 -> 0x40000000. Signed 0x8000*0x0001 -> 0xFFFF8000.
//      Signed 0x0007*0xFFFD -> 0xFFFFFFEB.
//   4. Backpressure: out_ready=0 for 10 cycles after out_valid.
//      -> product/out_valid stable, in_ready=0.
//      Release -> one handshake, IDLE next cycle.
//   5. Assert reset at RUN iteration 8.
//      -> out_valid=0, product=0, IDLE; the next op 2*3 returns 6.
//   6. RADIX_K=4: 0x1234*0x5678 -> 0x06260060, out_valid 5 cycles after accept.
//      Random signed/unsigned sweep vs reference model.

Source files
------------

// File: rtl/seq_mult_hs.sv
// Iterative shift-add multiplier with valid/ready handshakes on the operand
// and result sides. Retires RADIX_K multiplier bits per cycle. Operands are
// treated as two's complement or unsigned per transaction. Signed operands
// are multiplied as magnitudes and the sign is applied in a single fix-up
// cycle, so the accumulator itself never has to handle signed values.
`timescale 1ns/1ps

module seq_mult_hs #(
   parameter int WIDTH   = 16,
   parameter int RADIX_K = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic                 signed_mode,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   product,
   output logic                 busy
);

   localparam int N_ITER = WIDTH / RADIX_K;
   localparam int ITER_W = (N_ITER > 1) ? $clog2(N_ITER) : 1;
   localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(N_ITER - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t state, state_nx;

   logic [WIDTH-1:0]   mag_a_in;
   logic [WIDTH-1:0]   mag_b_in;
   logic [2*WIDTH-1:0] a_shift;    // multiplicand magnitude, pre-shifted to the current digit weight
   logic [WIDTH-1:0]   b_mag;      // remaining multiplier magnitude, lowest digit first
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] partial;
   logic [RADIX_K-1:0] digit;
   logic [ITER_W-1:0]  iter;
   logic               neg;

   // Operand magnitudes and the partial product for the current digit.
   always_comb begin
      mag_a_in = (signed_mode && a[WIDTH-1]) ? -a : a;
      mag_b_in = (signed_mode && b[WIDTH-1]) ? -b : b;
      digit    = b_mag[RADIX_K-1:0];
      // The running product never exceeds 2*WIDTH bits, so truncation here is exact.
      partial  = a_shift * {{(2*WIDTH-RADIX_K){1'b0}}, digit};
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state always uses non-blocking assignments so every
      // register samples pre-edge values regardless of block ordering.
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // Next-state logic: fixed-length RUN phase, one FIX cycle, then hold in DONE.
   always_comb begin
      // NOTE: defaulting to the current state first keeps every path assigned,
      // which is what prevents a latch being inferred.
      state_nx = state;
      case (state)
         IDLE: if (in_valid)          state_nx = RUN;
         RUN:  if (iter == LAST_ITER) state_nx = FIX;
         FIX:                         state_nx = DONE;
         DONE: if (out_ready)         state_nx = IDLE;
         default:                     state_nx = IDLE;
      endcase
   end

   // Handshake outputs decoded from the state.
   always_comb begin
      in_ready = (state == IDLE);
      busy     = (state != IDLE);
   end

   // Datapath: latch magnitudes on accept, accumulate digits, apply sign, hold result.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: every datapath register is reset, so an abort mid-RUN leaves no
      // stale partial result that could later surface on product.
      if (reset) begin
         a_shift   <= '0;
         b_mag     <= '0;
         acc       <= '0;
         iter      <= '0;
         neg       <= 1'b0;
         product   <= '0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_shift <= {{WIDTH{1'b0}}, mag_a_in};
                  b_mag   <= mag_b_in;
                  neg     <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                  acc     <= '0;
                  iter    <= '0;
               end
            end
            RUN: begin
               acc     <= acc + partial;
               a_shift <= a_shift << RADIX_K;
               b_mag   <= b_mag >> RADIX_K;
               iter    <= iter + 1'b1;
            end
            FIX: begin
               product   <= neg ? -acc : acc;
               out_valid <= 1'b1;
            end
            DONE: begin
               if (out_ready) out_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_mult_hs.sv
// Self-checking bench for seq_mult_hs. A WIDTH=16/RADIX_K=1 instance is
// checked every cycle against a transaction-level timing and arithmetic
// model; a RADIX_K=4 instance is checked per transaction.
`timescale 1ns/1ps

module tb_seq_mult_hs;

   localparam int W  = 16;
   localparam int N1 = 16;   // iterations for RADIX_K=1
   localparam int N4 = 4;    // iterations for RADIX_K=4

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   // RADIX_K = 1 instance
   logic          in_valid1, in_ready1, s1, out_valid1, out_ready1, busy1;
   logic [W-1:0]  a1, b1;
   logic [2*W-1:0] product1;

   // RADIX_K = 4 instance
   logic          in_valid4, in_ready4, s4, out_valid4, out_ready4, busy4;
   logic [W-1:0]  a4, b4;
   logic [2*W-1:0] product4;

   seq_mult_hs #(.WIDTH(W), .RADIX_K(1)) u_dut1 (
      .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
      .a(a1), .b(b1), .signed_mode(s1), .out_valid(out_valid1),
      .out_ready(out_ready1), .product(product1), .busy(busy1)
   );

   seq_mult_hs #(.WIDTH(W), .RADIX_K(4)) u_dut4 (
      .clk(clk), .reset(reset), .in_valid(in_valid4), .in_ready(in_ready4),
      .a(a4), .b(b4), .signed_mode(s4), .out_valid(out_valid4),
      .out_ready(out_ready4), .product(product4), .busy(busy4)
   );

   int n_checks = 0;
   int n_fail   = 0;
   bit started  = 1'b0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   // Exact product from plain integer arithmetic.
   function automatic logic [31:0] ref_mult(input logic [15:0] x, input logic [15:0] y, input logic s);
      longint px, py, p;
      px = s ? longint'($signed(x)) : longint'(x);
      py = s ? longint'($signed(y)) : longint'(y);
      p  = px * py;
      return p[31:0];
   endfunction

   function automatic logic [15:0] pick();
      case ($urandom_range(0, 5))
         0:       return 16'h0000;
         1:       return 16'hFFFF;
         2:       return 16'h8000;
         3:       return 16'h7FFF;
         default: return 16'($urandom);
      endcase
   endfunction

   // Transaction model of the RADIX_K=1 instance: busy from accept until the
   // result is taken, result visible N1+1 cycles after accept, product held.
   bit          m_busy = 1'b0;
   bit          m_ovalid = 1'b0;
   int          m_cnt = 0;
   logic [31:0] m_exp = '0;
   logic [31:0] m_last = '0;

   initial begin
      forever begin
         @(posedge clk or posedge reset);
         if (reset) begin
            m_busy = 1'b0; m_ovalid = 1'b0; m_cnt = 0; m_last = '0;
         end else if (!m_busy) begin
            if (in_valid1) begin
               m_busy = 1'b1; m_cnt = 0; m_exp = ref_mult(a1, b1, s1);
            end
         end else if (m_ovalid) begin
            if (out_ready1) begin
               m_ovalid = 1'b0; m_busy = 1'b0;
            end
         end else begin
            m_cnt++;
            if (m_cnt == N1 + 1) begin
               m_ovalid = 1'b1; m_last = m_exp;
            end
         end
      end
   end

   // Per-cycle comparison of the RADIX_K=1 instance against the model.
   initial begin
      wait (started);
      forever begin
         @(negedge clk);
         check("in_ready",  in_ready1,  !m_busy);
         check("busy",      busy1,      m_busy);
         check("out_valid", out_valid1, m_ovalid);
         check("product",   product1,   m_last);
      end
   end

   // One transaction on the RADIX_K=1 instance; out_ready held low for
   // 'hold' cycles after out_valid rises.
   task automatic op1(input logic [15:0] a, input logic [15:0] b, input logic s,
                      input int hold, output logic [31:0] got, output int lat);
      a1 = a; b1 = b; s1 = s; in_valid1 = 1'b1; out_ready1 = (hold == 0);
      @(posedge clk); #1;
      in_valid1 = 1'b0; a1 = 16'($urandom); b1 = 16'($urandom); s1 = 1'($urandom);
      lat = 0;
      while (!out_valid1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      got = product1;
      if (!out_valid1) begin
         check("op1_timeout", out_valid1, 1);
         return;
      end
      if (hold > 0) begin
         repeat (hold) begin @(posedge clk); #1; end
         check("bp_in_ready",  in_ready1,  0);
         check("bp_out_valid", out_valid1, 1);
      end
      out_ready1 = 1'b1;
      @(posedge clk); #1;
      check("post_hs_in_ready",  in_ready1,  1);
      check("post_hs_out_valid", out_valid1, 0);
   endtask

   task automatic op4(input logic [15:0] a, input logic [15:0] b, input logic s,
                      output logic [31:0] got, output int lat);
      a4 = a; b4 = b; s4 = s; in_valid4 = 1'b1;
      @(posedge clk); #1;
      in_valid4 = 1'b0; a4 = 16'($urandom); b4 = 16'($urandom);
      lat = 0;
      while (!out_valid4 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      got = product4;
      if (!out_valid4) begin
         check("op4_timeout", out_valid4, 1);
         return;
      end
      @(posedge clk); #1;
      check("op4_in_ready", in_ready4, 1);
   endtask

   initial begin
      logic [31:0] got;
      int          lat;
      logic [15:0] ra, rb;
      logic        rs;

      in_valid1 = 1'b0; a1 = '0; b1 = '0; s1 = 1'b0; out_ready1 = 1'b1;
      in_valid4 = 1'b0; a4 = '0; b4 = '0; s4 = 1'b0; out_ready4 = 1'b1;

      // Reset state, with in_valid asserted to show it is ignored.
      repeat (2) @(posedge clk);
      #1 in_valid1 = 1'b1;
      @(posedge clk); #1;
      in_valid1 = 1'b0;
      check("rst_product",   product1,   0);
      check("rst_out_valid", out_valid1, 0);
      check("rst_in_ready",  in_ready1,  1);
      check("rst_busy",      busy1,      0);
      check("rst_product4",  product4,   0);
      reset = 1'b0;
      started = 1'b1;
      @(posedge clk); #1;

      // Directed products and latency.
      op1(16'd3, 16'd5, 1'b0, 0, got, lat);
      check("u3x5", got, 32'h0000000F);
      check("u3x5_latency", lat, N1 + 1);
      op1(16'hFFFF, 16'hFFFF, 1'b0, 0, got, lat);
      check("uFFFFxFFFF", got, 32'hFFFE0001);
      op1(16'hFFFF, 16'hFFFF, 1'b1, 0, got, lat);
      check("s-1x-1", got, 32'h00000001);
      op1(16'h8000, 16'h8000, 1'b1, 0, got, lat);
      check("sminxmin", got, 32'h40000000);
      op1(16'h8000, 16'h0001, 1'b1, 0, got, lat);
      check("sminx1", got, 32'hFFFF8000);
      op1(16'h0007, 16'hFFFD, 1'b1, 0, got, lat);
      check("s7x-3", got, 32'hFFFFFFEB);
      op1(16'h0000, 16'h1234, 1'b1, 0, got, lat);
      check("zero_op", got, 32'h00000000);
      check("zero_latency", lat, N1 + 1);

      // Backpressure: result held for 10 cycles with out_ready low.
      op1(16'h00AB, 16'h0100, 1'b0, 10, got, lat);
      check("bp_product", product1, 32'h0000AB00);

      // Reset during RUN iteration 8 aborts the operation.
      a1 = 16'd1000; b1 = 16'd1000; s1 = 1'b0; in_valid1 = 1'b1; out_ready1 = 1'b1;
      @(posedge clk); #1;
      in_valid1 = 1'b0;
      repeat (8) begin @(posedge clk); #1; end
      reset = 1'b1;
      #2;
      check("abort_out_valid", out_valid1, 0);
      check("abort_product",   product1,   0);
      check("abort_in_ready",  in_ready1,  1);
      check("abort_busy",      busy1,      0);
      @(posedge clk); #1;
      reset = 1'b0;
      op1(16'd2, 16'd3, 1'b0, 0, got, lat);
      check("after_abort_2x3", got, 32'd6);

      // Random sweep on the RADIX_K=1 instance.
      for (int i = 0; i < 40; i++) begin
         ra = pick(); rb = pick(); rs = 1'($urandom);
         op1(ra, rb, rs, int'($urandom_range(0, 3)), got, lat);
         check("rand1", got, ref_mult(ra, rb, rs));
      end

      // RADIX_K=4 instance: directed then random.
      op4(16'h1234, 16'h5678, 1'b0, got, lat);
      check("k4_1234x5678", got, 32'h06260060);
      check("k4_latency", lat, N4 + 1);
      for (int i = 0; i < 30; i++) begin
         ra = pick(); rb = pick(); rs = 1'($urandom);
         op4(ra, rb, rs, got, lat);
         check("rand4", got, ref_mult(ra, rb, rs));
         check("rand4_latency", lat, N4 + 1);
      end

      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
